// File: rtl/ram_dma_master.sv
// ram_dma_master: sole initiator on the byte RAM port. Performs block COPY
// (src -> dst) or FILL (constant byte) of len elements, one byte per RAM
// location, confirming every write through the RAM's write_okay toggle.
// Optional feature: define RAM_DMA_VERIFY_EN to add a read-back VERIFY state
// after every acknowledged write.
module ram_dma_master #(
  parameter int ADDR_W      = 32,
  parameter int ADDR_STRIDE = 4,
  parameter int LEN_W       = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [7:0]        fill_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i,
  input  logic              ram_wok_i
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_WAIT_ACK,
    S_VERIFY,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;        // 0 = COPY, 1 = FILL
  logic [ADDR_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [7:0]         fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wok_ref_q;
  logic               err_d;
  logic               advance;
  logic               en_d, we_d, busy_d, done_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [7:0]         wdata_d;

  // Next-state, next-config and next-value of every registered RAM output.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned; that is what keeps this block free of latches.
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    err_d   = err_o;
    advance = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d = mode_i;
          src_d  = src_addr_i;
          dst_d  = dst_addr_i;
          rem_d  = len_i;
          fill_d = fill_i;
          err_d  = 1'b0;
          if (len_i == '0) state_d = S_DONE;
          else             state_d = mode_i ? S_WR : S_RD;
        end
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ram_wok_i != wok_ref_q) begin
`ifdef RAM_DMA_VERIFY_EN
          state_d = S_VERIFY;
`else
          advance = 1'b1;
`endif
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          // Abort: remaining bytes are left untouched.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef RAM_DMA_VERIFY_EN
      S_VERIFY: begin
        // ram_wdata_o still holds the byte that was just written.
        if (ram_rdata_i != ram_wdata_o) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          advance = 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Element finished: step both pointers (silent wrap) and the count.
    if (advance) begin
      src_d = src_q + ADDR_W'(ADDR_STRIDE);
      dst_d = dst_q + ADDR_W'(ADDR_STRIDE);
      rem_d = rem_q - LEN_W'(1);
      if (rem_q == LEN_W'(1)) state_d = S_DONE;
      else                    state_d = mode_q ? S_WR : S_RD;
    end

    // RAM outputs are registered, so they are derived from the next state.
    en_d    = (state_d == S_RD) || (state_d == S_WR) || (state_d == S_VERIFY);
    we_d    = (state_d == S_WR);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    addr_d  = ram_addr_o;
    if (state_d == S_RD)                            addr_d = src_d;
    else if (state_d == S_WR || state_d == S_VERIFY) addr_d = dst_d;
    wdata_d = ram_wdata_o;
    if (state_d == S_WR) wdata_d = mode_d ? fill_d : ram_rdata_i;
  end

  // State, configuration and registered outputs; synchronous reset aborts.
  always_ff @(posedge clk) begin
    // NOTE: reset clears only these control/datapath registers; there is no
    // memory array here that would need (or want) a reset.
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      wok_ref_q   <= 1'b0;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      ram_en_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // same pre-edge values regardless of statement order.
      state_q     <= state_d;
      mode_q      <= mode_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      if (state_q == S_WR) wok_ref_q <= ram_wok_i;
      err_o       <= err_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      ram_en_o    <= en_d;
      ram_we_o    <= we_d;
      ram_addr_o  <= addr_d;
      ram_wdata_o <= wdata_d;
    end
  end

endmodule

// File: tb/tb_ram_dma_master.sv
// Self-checking bench for ram_dma_master: a byte RAM model with write_okay
// toggle plus a transfer-level reference model (byte array + cycle formulas).
module tb_ram_dma_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [15:0] len = '0;
  logic [7:0]  fill = '0;
  logic        busy_o, done_o, err_o;
  logic        ram_en_o, ram_we_o;
  logic [31:0] ram_addr_o;
  logic [7:0]  ram_wdata_o;
  logic [7:0]  ram_rdata;
  logic        ram_wok = 1'b0;

  logic        stuck = 1'b0;     // freeze write_okay (unresponsive RAM)
  logic        corrupt = 1'b0;   // invert read data
  logic        load_req = 1'b0;

  logic [7:0]  mem      [0:1023];
  logic [7:0]  init_mem [0:1023];
  logic [7:0]  exp_mem  [0:1023];
  logic [31:0] wr_addr  [0:63];
  int          wr_cnt = 0;

  int total = 0;
  int bad   = 0;

`ifdef RAM_DMA_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  ram_dma_master dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .mode_i     (mode),
    .src_addr_i (src),
    .dst_addr_i (dst),
    .len_i      (len),
    .fill_i     (fill),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .ram_en_o   (ram_en_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata),
    .ram_wok_i  (ram_wok)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, write_okay toggles on each write edge.
  assign ram_rdata = ram_en_o ? (mem[ram_addr_o[11:2]] ^ {8{corrupt}}) : 8'h00;

  always @(posedge clk) begin
    if (rst) ram_wok <= 1'b0;
    else if (ram_en_o && ram_we_o) begin
      if (!stuck) ram_wok <= ~ram_wok;
      wr_addr[wr_cnt % 64] <= ram_addr_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (load_req) mem = init_mem;
    else if (ram_en_o && ram_we_o) mem[ram_addr_o[11:2]] = ram_wdata_o;
  end

  task automatic load_apply();
    exp_mem = init_mem;
    load_req = 1'b1;
    @(negedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < 1024; i++) init_mem[i] = 8'($urandom);
    load_apply();
  endtask

  // Reference: the first n elements of the transfer, in ascending order.
  task automatic model_xfer(input bit m, input logic [31:0] s, input logic [31:0] d,
                            input int n, input logic [7:0] f);
    logic [31:0] sa, da;
    for (int i = 0; i < n; i++) begin
      sa = s + 32'(i * 4);
      da = d + 32'(i * 4);
      exp_mem[da[11:2]] = m ? f : exp_mem[sa[11:2]];
    end
  endtask

  function automatic int exp_lat(input bit m, input int l);
    return (l == 0) ? 1 : l * ((m ? 2 : 3) + VER) + 1;
  endfunction

  function automatic int count_diffs();
    int n = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  // Pulse start with a config, optionally pulse a rival start at cycle gcycle,
  // and observe until done_o (latency counted from the start cycle).
  task automatic run_xfer(input bit m, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l, input logic [7:0] f, input int gcycle,
                          output int lat, output int busy_n, output int we_n,
                          output bit en_seen, output bit tmo);
    @(posedge clk); #1;
    mode = m; src = s; dst = d; len = l; fill = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_n = 0; we_n = 0; en_seen = 1'b0; tmo = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      if (c == gcycle) begin
        start = 1'b1; mode = ~m; src = 32'h200; dst = 32'h300; len = 16'd5; fill = 8'hEE;
      end else begin
        start = 1'b0;
      end
      if (ram_en_o) en_seen = 1'b1;
      if (busy_o)   busy_n++;
      if (ram_we_o) we_n++;
      if (done_o) begin
        lat = c; tmo = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (tmo) begin
      total++; bad++;
      $display("FAIL xfer_timeout: done_o not seen within 400 cycles (required done_o=1)");
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++;
    if ({busy_o, done_o, err_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b en=%b we=%b addr=%h wdata=%h (required all 0)",
               busy_o, done_o, err_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    int lat, bn, wn; bit en, tmo;
    load_random();
    run_xfer(1'b1, 32'h0, 32'h100, 16'd4, 8'hA5, 0, lat, bn, wn, en, tmo);
    model_xfer(1'b1, 32'h0, 32'h100, 4, 8'hA5);
    total++;
    if (lat !== exp_lat(1'b1, 4)) begin
      bad++; $display("FAIL fill_latency: got %0d required %0d", lat, exp_lat(1'b1, 4));
    end
    total++;
    if (err_o !== 1'b0) begin bad++; $display("FAIL fill_err: got %b required 0", err_o); end
    @(posedge clk); #1;
    total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL fill_done_pulse: done=%b busy=%b one cycle later (required 0 0)", done_o, busy_o);
    end
    total++;
    if (count_diffs() != 0) begin
      bad++; $display("FAIL fill_mem: %0d bytes differ (required 0)", count_diffs());
    end
  endtask

  task automatic test_copy();
    int lat, bn, wn; bit en, tmo;
    for (int i = 0; i < 1024; i++) init_mem[i] = 8'(i * 7);
    init_mem[0] = 8'h11; init_mem[1] = 8'h22; init_mem[2] = 8'h33;
    load_apply();
    run_xfer(1'b0, 32'h0, 32'h40, 16'd3, 8'h00, 0, lat, bn, wn, en, tmo);
    model_xfer(1'b0, 32'h0, 32'h40, 3, 8'h00);
    total++;
    if (wn != 3) begin bad++; $display("FAIL copy_we_cycles: got %0d required 3", wn); end
    total++;
    if (bn != 9) begin bad++; $display("FAIL copy_busy_cycles: got %0d required 9", bn); end
    total++;
    if (lat != exp_lat(1'b0, 3)) begin
      bad++; $display("FAIL copy_latency: got %0d required %0d", lat, exp_lat(1'b0, 3));
    end
    total++;
    if (mem[16] !== 8'h11 || mem[17] !== 8'h22 || mem[18] !== 8'h33 || count_diffs() != 0) begin
      bad++; $display("FAIL copy_mem: dst=%h %h %h diffs=%0d (required 11 22 33, 0)",
                      mem[16], mem[17], mem[18], count_diffs());
    end
  endtask

  task automatic test_len0();
    int lat, bn, wn; bit en, tmo;
    run_xfer(1'b0, 32'h0, 32'h80, 16'd0, 8'h00, 0, lat, bn, wn, en, tmo);
    total++;
    if (lat != 1 || en !== 1'b0 || err_o !== 1'b0) begin
      bad++; $display("FAIL len0: latency=%0d en_seen=%b err=%b (required 1 0 0)", lat, en, err_o);
    end
  endtask

  task automatic test_timeout();
    int lat, bn, wn; bit en, tmo;
    load_random();
    stuck = 1'b1;
    run_xfer(1'b1, 32'h0, 32'h80, 16'd3, 8'h5A, 0, lat, bn, wn, en, tmo);
    model_xfer(1'b1, 32'h0, 32'h80, 1, 8'h5A);
    stuck = 1'b0;
    total++;
    if (lat != 17 || err_o !== 1'b1) begin
      bad++; $display("FAIL timeout_abort: latency=%0d err=%b (required 17 1)", lat, err_o);
    end
    total++;
    if (wn != 1 || count_diffs() != 0) begin
      bad++; $display("FAIL timeout_mem: writes=%0d diffs=%0d (required 1 0)", wn, count_diffs());
    end
    run_xfer(1'b1, 32'h0, 32'h90, 16'd1, 8'h77, 0, lat, bn, wn, en, tmo);
    model_xfer(1'b1, 32'h0, 32'h90, 1, 8'h77);
    total++;
    if (err_o !== 1'b0 || lat != exp_lat(1'b1, 1) || count_diffs() != 0) begin
      bad++; $display("FAIL timeout_err_clear: err=%b latency=%0d diffs=%0d (required 0 %0d 0)",
                      err_o, lat, count_diffs(), exp_lat(1'b1, 1));
    end
  endtask

  task automatic test_back_to_back();
    int lat, bn, wn; bit en, tmo;
    load_random();
    run_xfer(1'b0, 32'h0, 32'h40, 16'd2, 8'h00, 2, lat, bn, wn, en, tmo);
    model_xfer(1'b0, 32'h0, 32'h40, 2, 8'h00);
    total++;
    if (lat != exp_lat(1'b0, 2) || wn != 2 || count_diffs() != 0) begin
      bad++; $display("FAIL start_while_busy: latency=%0d writes=%0d diffs=%0d (required %0d 2 0)",
                      lat, wn, count_diffs(), exp_lat(1'b0, 2));
    end
    // The rival start landed mid-transfer and must not have been queued.
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (busy_o !== 1'b0 || ram_en_o !== 1'b0) begin
        bad++; $display("FAIL start_not_queued: busy=%b en=%b (required 0 0)", busy_o, ram_en_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit pulsed = 1'b0;
    load_random();
    @(posedge clk); #1;
    mode = 1'b0; src = 32'h0; dst = 32'h100; len = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy_o, done_o, err_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o} !== '0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b err=%b en=%b we=%b addr=%h wdata=%h (required all 0)",
               busy_o, done_o, err_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o);
    end
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_o || ram_en_o) pulsed = 1'b1;
    end
    total++;
    if (pulsed) begin bad++; $display("FAIL reset_mid_idle: activity after reset (required none)"); end
  endtask

  task automatic test_wrap();
    int lat, bn, wn, base; bit en, tmo;
    load_random();
    base = wr_cnt;
`ifdef RAM_DMA_VERIFY_EN
    corrupt = 1'b1;
    run_xfer(1'b1, 32'h0, 32'hFFFF_FFFC, 16'd2, 8'h3C, 0, lat, bn, wn, en, tmo);
    corrupt = 1'b0;
    model_xfer(1'b1, 32'h0, 32'hFFFF_FFFC, 1, 8'h3C);
    total++;
    if (err_o !== 1'b1 || wn != 1 || lat != 4 || count_diffs() != 0) begin
      bad++; $display("FAIL verify_miss: err=%b writes=%0d latency=%0d diffs=%0d (required 1 1 4 0)",
                      err_o, wn, lat, count_diffs());
    end
`else
    run_xfer(1'b1, 32'h0, 32'hFFFF_FFFC, 16'd2, 8'h3C, 0, lat, bn, wn, en, tmo);
    model_xfer(1'b1, 32'h0, 32'hFFFF_FFFC, 2, 8'h3C);
    total++;
    if (wr_cnt - base != 2 || wr_addr[(base + 1) % 64] !== 32'h0) begin
      bad++; $display("FAIL wrap_addr: writes=%0d second addr=%h (required 2 00000000)",
                      wr_cnt - base, wr_addr[(base + 1) % 64]);
    end
    total++;
    if (count_diffs() != 0 || err_o !== 1'b0) begin
      bad++; $display("FAIL wrap_mem: diffs=%0d err=%b (required 0 0)", count_diffs(), err_o);
    end
`endif
  endtask

  task automatic test_random();
    int lat, bn, wn, l; bit en, tmo, m;
    logic [31:0] s, d;
    load_random();
    for (int k = 0; k < 10; k++) begin
      m = 1'($urandom);
      l = $urandom_range(0, 8);
      s = 32'($urandom_range(0, 400)) << 2;
      d = 32'($urandom_range(0, 400)) << 2;
      run_xfer(m, s, d, 16'(l), 8'($urandom), 0, lat, bn, wn, en, tmo);
      model_xfer(m, s, d, l, fill);
      total++;
      if (lat != exp_lat(m, l) || wn != l || bn != lat - 1 || err_o !== 1'b0) begin
        bad++; $display("FAIL rand_timing[%0d]: lat=%0d we=%0d busy=%0d err=%b (required %0d %0d %0d 0)",
                        k, lat, wn, bn, err_o, exp_lat(m, l), l, exp_lat(m, l) - 1);
      end
      total++;
      if (count_diffs() != 0) begin
        bad++; $display("FAIL rand_mem[%0d]: %0d bytes differ (required 0)", k, count_diffs());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) init_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    test_reset();
    test_fill();
    test_copy();
    test_len0();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
